// File: rtl/led_status_ctrl.sv
// LED status/error indicator: PWM-dimmed status display, with a sticky error code
// blinked in bursts of NUM_BLINKS flashes followed by a dark gap.
module led_status_ctrl #(
    parameter int unsigned LED_W           = 4,
    parameter int unsigned HALF_PERIOD_CYC = 12000000,
    parameter int unsigned NUM_BLINKS      = 3,
    parameter int unsigned GAP_TICKS       = 4,
    parameter int unsigned PWM_W           = 4
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic [LED_W-1:0] status,
    input  logic             error_flag,
    input  logic [LED_W-1:0] error_code,
    input  logic             err_clr,
    input  logic [PWM_W-1:0] brightness,
    output logic [LED_W-1:0] led,
    output logic             err_latched
);

    localparam int unsigned TICK_W  = $clog2(HALF_PERIOD_CYC);
    localparam int unsigned PULSE_W = (NUM_BLINKS > 1) ? $clog2(NUM_BLINKS) : 1;
    localparam int unsigned GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(HALF_PERIOD_CYC - 1);
    localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(NUM_BLINKS - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_t;

    state_t             state_q;
    logic [LED_W-1:0]   code_q;
    logic [TICK_W-1:0]  tick_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               pwm_on;
    logic               tick;

    assign pwm_on = (&brightness) | (pwm_cnt < brightness);
    assign tick   = (tick_cnt == TICK_MAX);

    // A new error in the same cycle as a clear wins and recaptures its code.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            err_latched <= 1'b0;
            code_q      <= '0;
        end else if (error_flag) begin
            err_latched <= 1'b1;
            if (!err_latched || err_clr) begin
                code_q <= error_code;
            end
        end else if (err_clr) begin
            err_latched <= 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tick_cnt  <= '0;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            led       <= '0;
        end else begin
            case (state_q)
                StIdle:  led <= pwm_on ? status : '0;
                StOn:    led <= pwm_on ? code_q : '0;
                default: led <= '0;
            endcase

            if (state_q != StIdle && !err_latched) begin
                state_q  <= StIdle;
                tick_cnt <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (err_latched) begin
                            state_q   <= StOn;
                            pulse_cnt <= '0;
                        end
                    end
                    StOn: begin
                        if (tick) begin
                            state_q <= StOff;
                        end
                    end
                    StOff: begin
                        if (tick) begin
                            if (pulse_cnt == PULSE_MAX) begin
                                state_q   <= StGap;
                                pulse_cnt <= '0;
                                gap_cnt   <= '0;
                            end else begin
                                state_q   <= StOn;
                                pulse_cnt <= pulse_cnt + PULSE_W'(1);
                            end
                        end
                    end
                    StGap: begin
                        if (tick) begin
                            if (gap_cnt == GAP_MAX) begin
                                state_q <= StOn;
                            end else begin
                                gap_cnt <= gap_cnt + GAP_W'(1);
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase

                // Phase timer only runs while blinking; entry into StOn starts from zero.
                if (state_q == StIdle) begin
                    tick_cnt <= '0;
                end else begin
                    tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with HALF_PERIOD_CYC=8, NUM_BLINKS=2, GAP_TICKS=3, PWM_W=2.
module tb_led_status_ctrl;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [3:0] status;
    logic       error_flag;
    logic [3:0] error_code;
    logic       err_clr;
    logic [1:0] brightness;
    logic [3:0] led;
    logic       err_latched;

    int n_checks = 0;
    int n_errors = 0;

    led_status_ctrl #(
        .LED_W           (4),
        .HALF_PERIOD_CYC (8),
        .NUM_BLINKS      (2),
        .GAP_TICKS       (3),
        .PWM_W           (2)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .status      (status),
        .error_flag  (error_flag),
        .error_code  (error_code),
        .err_clr     (err_clr),
        .brightness  (brightness),
        .led         (led),
        .err_latched (err_latched)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    // k = edges after the latching edge; led first shows the code at k=2, period 56:
    // 8 on, 8 off, 8 on, 8 off + 24 gap.
    function automatic logic [3:0] burst_exp(input int k, input logic [3:0] code);
        int p;
        p = (k - 2) % 56;
        return (p < 8 || (p >= 16 && p < 24)) ? code : 4'h0;
    endfunction

    initial begin
        int cnt_f;
        int cnt_bad;
        int pos[2];

        rst_n      = 1'b0;
        status     = 4'hA;
        error_flag = 1'b0;
        error_code = 4'h0;
        err_clr    = 1'b0;
        brightness = 2'd3;

        // 1: reset state and full-brightness status display
        #22;
        check("reset_led", 32'(led), 32'h0);
        check("reset_err", 32'(err_latched), 32'h0);
        rst_n = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("status_a_%0d", i), 32'(led), 32'hA);
        end
        check("status_err", 32'(err_latched), 32'h0);

        // 2: quarter duty, then zero brightness
        brightness = 2'd1;
        status     = 4'hF;
        step();
        cnt_f   = 0;
        cnt_bad = 0;
        pos[0]  = 0;
        pos[1]  = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (led == 4'hF) begin
                if (cnt_f < 2) pos[cnt_f] = i;
                cnt_f++;
            end else if (led != 4'h0) begin
                cnt_bad++;
            end
        end
        check("pwm1_on_count", 32'(cnt_f), 32'd2);
        check("pwm1_bad_value", 32'(cnt_bad), 32'd0);
        check("pwm1_spacing", 32'(pos[1] - pos[0]), 32'd4);
        brightness = 2'd0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("pwm0_%0d", i), 32'(led), 32'h0);
        end

        // 3 + 4: single-cycle error pulse, ignored second code, then clear
        brightness = 2'd3;
        status     = 4'hC;
        step();
        step();
        check("idle_status_c", 32'(led), 32'hC);
        error_code = 4'h5;
        error_flag = 1'b1;
        step();
        error_flag = 1'b0;
        check("latch_edge_err", 32'(err_latched), 32'h1);
        check("latch_edge_led", 32'(led), 32'hC);
        for (int k = 1; k <= 120; k++) begin
            step();
            if (k == 1) check("burst5_k1", 32'(led), 32'hC);
            else check($sformatf("burst5_k%0d", k), 32'(led), 32'(burst_exp(k, 4'h5)));
            if (k == 30) begin
                error_flag = 1'b1;
                error_code = 4'h3;
            end
            if (k == 31) error_flag = 1'b0;
            if (k == 60 || k == 120) check($sformatf("burst5_err_k%0d", k), 32'(err_latched), 32'h1);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clear_err", 32'(err_latched), 32'h0);
        step();
        step();
        check("clear_led_status", 32'(led), 32'hC);

        // 5: clear and error in the same cycle, recapture code 9
        error_code = 4'h5;
        error_flag = 1'b1;
        step();
        error_flag = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k < 2) check("recap_k1", 32'(led), 32'hC);
            else check($sformatf("recap_k%0d", k), 32'(led),
                       32'(burst_exp(k, (k < 6) ? 4'h5 : 4'h9)));
            if (k == 4) begin
                err_clr    = 1'b1;
                error_flag = 1'b1;
                error_code = 4'h9;
            end
            if (k == 5) begin
                err_clr    = 1'b0;
                error_flag = 1'b0;
                check("recap_err", 32'(err_latched), 32'h1);
            end
        end
        check("gap_err_before_rst", 32'(err_latched), 32'h1);

        // 6: asynchronous reset mid-gap, then clean status display
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_err", 32'(err_latched), 32'h0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        step();
        step();
        for (int i = 0; i < 70; i++) begin
            step();
            check($sformatf("post_rst_%0d", i), 32'(led), 32'hC);
        end
        check("post_rst_err", 32'(err_latched), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Parametrised LED status/error indicator, the successor to the fixed 4-LED SDRAM-test display.
- Normal operation: shows a status vector (e.g. cycle counter) on LED_W LEDs, dimmed by a PWM brightness control.
- A sticky error latch captures an error code and blinks it in bursts of NUM_BLINKS flashes separated by a dark gap.
- The latch is cleared by a software/button strobe.

Parameters:
- LED_W, 4: number of LEDs; width of status, error code and led.
- HALF_PERIOD_CYC, 12000000: clock cycles per blink half-period (on time = off time). Must be ≥2.
- NUM_BLINKS, 3: code flashes per burst. Must be ≥1.
- GAP_TICKS, 4: half-periods of dark gap after each burst. Must be ≥1.
- PWM_W, 4: width of brightness and of the PWM counter.

Ports:
- clk_50m, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- status, input, LED_W: value shown when no error is latched.
- error_flag, input, 1: error indication, level or pulse; sampled every cycle.
- error_code, input, LED_W: code captured with the error.
- err_clr, input, 1: one-cycle strobe that clears the latched error.
- brightness, input, PWM_W: LED duty. 0 = off; all-ones = 100%; otherwise brightness/2^PWM_W.
- led, output, LED_W: registered LED drive.
- err_latched, output, 1: sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - led=0, err_latched=0, code_q=0.
  - FSM=IDLE; tick_cnt, pulse_cnt, gap_cnt and pwm_cnt all 0.
- Error latch, evaluated at each clock edge:
  - error_flag=1 and err_latched=0: err_latched<=1, code_q<=error_code.
  - error_flag=1 and err_latched=1: code_q holds the first code; later codes are ignored.
  - err_clr=1 and error_flag=0: err_latched<=0.
  - err_clr=1 and error_flag=1 in the same cycle: the error wins. err_latched stays/becomes 1 and code_q<=error_code (recapture).
- PWM:
  - pwm_cnt free-runs mod 2^PWM_W.
  - pwm_on = (brightness==all-ones) | (pwm_cnt < brightness).
- Tick:
  - tick_cnt is held at 0 in IDLE. Otherwise it counts 0..HALF_PERIOD_CYC-1 and wraps.
  - tick = (tick_cnt==HALF_PERIOD_CYC-1), combinational.
- FSM, priority top-down:
  - In any non-IDLE state, err_latched=0 → IDLE.
  - IDLE: err_latched=1 → ON; pulse_cnt<=0.
  - ON: on tick → OFF.
  - OFF, on tick:
    - pulse_cnt==NUM_BLINKS-1 → GAP; pulse_cnt<=0, gap_cnt<=0.
    - Otherwise pulse_cnt++ → ON.
  - GAP, on tick:
    - gap_cnt==GAP_TICKS-1 → ON.
    - Otherwise gap_cnt++.
- LED output, registered from the current state (one cycle after the state changes):
  - IDLE: led <= pwm_on ? status : 0.
  - ON: led <= pwm_on ? code_q : 0.
  - OFF or GAP: led <= 0.
- Latency:
  - error_flag high at edge n → err_latched=1 after edge n.
  - FSM=ON after edge n+1.
  - led shows code_q after edge n+2.
  - err_clr: IDLE after the next edge; led shows status one edge later.
- Timing:
  - Each ON and OFF phase lasts exactly HALF_PERIOD_CYC cycles.
  - The gap lasts GAP_TICKS*HALF_PERIOD_CYC cycles.
  - A full burst period is (2*NUM_BLINKS+GAP_TICKS)*HALF_PERIOD_CYC cycles.
- Error code 0 produces dark ON phases; this is legal.
- Reset mid-burst returns everything to reset values immediately.
- A status change in IDLE appears on led after one edge. In error states, status is ignored.

Test Plan:
Bench parameters: LED_W=4, HALF_PERIOD_CYC=8, NUM_BLINKS=2, GAP_TICKS=3, PWM_W=2.
1. Reset, then brightness=3, status=4'hA → led=4'hA steady from the 2nd edge after reset release; err_latched=0.
2. brightness=1, status=4'hF → led=4'hF exactly 1 cycle of every 4, otherwise 0. brightness=0 → led constantly 0.
3. Pulse error_flag for 1 cycle with error_code=4'h5, brightness=3:
   - led=5 for 8 cycles, 0 for 8, 5 for 8, 0 for 8 (off) + 24 (gap).
   - Pattern repeats with a 56-cycle period.
   - err_latched stays 1.
4. While latched, pulse error_flag with error_code=4'h3 → flashes still show 5. Then assert err_clr alone → err_latched=0 next edge; led=status two edges after the clear.
5. err_clr and error_flag both high in one cycle with code 4'h9 → err_latched stays 1 and subsequent flashes show 9.
6. Assert rst_n low mid-GAP → led=0, err_latched=0 immediately (asynchronous). After release, normal status display resumes with no residual blink.
